mlp_seq_ctrl: RTL
=================

MLP_SEQ_CTRL -- requirements
Module: mlp_seq_ctrl

Parameters
REQ-001 The block SHALL have parameter N_IN, default 784, meaning inputs per image (layer-1 fan-in).
REQ-002 The block SHALL have parameter N_HID, default 200, meaning hidden neurons.
REQ-003 The block SHALL have parameter N_OUT, default 10, meaning output neurons.
REQ-004 The block SHALL have parameter N_IMG, default 10, meaning images per run (input SRAM banks).

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports start (in, 1), abort (in, 1), busy (out, 1) and done (out, 1).
REQ-008 The block SHALL have layer-1 ports w1_addr (out, 18), in_addr (out, 10), img_sel (out, 4), mac1_en, mac1_start, mac1_last (out, 1 each) and sig_ready (in, 1).
REQ-009 The block SHALL have hidden-buffer ports hid_we (out, 1), hid_waddr (out, 8) and hid_raddr (out, 8).
REQ-010 The block SHALL have layer-2 ports w2_addr (out, 12), mac2_en, mac2_start, mac2_last (out, 1 each), mac2_done (in, 1), out_we (out, 1) and out_idx (out, 4).

Function
REQ-011 The block SHALL implement the states IDLE, L1_RUN, L1_WAIT, L2_RUN, L2_WAIT, NEXT_IMG and FIN.
REQ-012 In IDLE, start=1 SHALL clear counters i, j, k, h and img to 0, set busy=1 and enter L1_RUN on the next edge.
REQ-013 In L1_RUN, each cycle SHALL drive mac1_en=1, in_addr=j, w1_addr=i*N_IN+j and img_sel=img; w1_addr SHALL be produced by an incrementing counter, not a multiplier.
REQ-014 In L1_RUN, mac1_start SHALL be 1 only when j=0 and mac1_last SHALL be 1 only when j=N_IN-1; the j=N_IN-1 cycle SHALL move to L1_WAIT.
REQ-015 In L1_WAIT, mac1_en SHALL be 0 and w1_addr SHALL hold; on sig_ready=1 the block SHALL pulse hid_we=1 for exactly one cycle with hid_waddr=i.
REQ-016 After the REQ-015 pulse, if i<N_HID-1 then i SHALL increment, j SHALL clear and the state SHALL return to L1_RUN; otherwise the state SHALL enter L2_RUN with k=h=0.
REQ-017 In L2_RUN, each cycle SHALL drive mac2_en=1, hid_raddr=h and w2_addr=k*N_HID+h (counter-generated); mac2_start SHALL be 1 when h=0 and mac2_last SHALL be 1 when h=N_HID-1, after which the state SHALL enter L2_WAIT.
REQ-018 In L2_WAIT, mac2_done=1 SHALL pulse out_we for one cycle with out_idx=k; if k<N_OUT-1 the block SHALL increment k, clear h and return to L2_RUN; otherwise it SHALL enter NEXT_IMG.
REQ-019 In NEXT_IMG, if img<N_IMG-1 the block SHALL increment img, clear i, j and w1_addr, and enter L1_RUN; otherwise it SHALL enter FIN.
REQ-020 FIN SHALL assert done=1 for exactly one cycle, then deassert busy and return to IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored.
REQ-022 abort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge with all enables and strobes at 0, without a done pulse; abort SHALL take priority over start, sig_ready and mac2_done in the same cycle.
REQ-023 sig_ready or mac2_done arriving outside its WAIT state SHALL be ignored.
REQ-024 All strobe outputs (mac*_start, mac*_last, hid_we, out_we, done) SHALL be registered and glitch-free.
REQ-025 Address outputs SHALL never exceed N_IN*N_HID-1 (w1_addr) or N_OUT*N_HID-1 (w2_addr); no counter SHALL wrap during a run.

Reset
REQ-026 While reset=0, the block SHALL be in IDLE with all outputs and counters at 0; this SHALL take effect asynchronously.
REQ-027 After reset is released, the block SHALL wait for start; a reset asserted mid-run SHALL abandon the run without a done pulse.

Verification
REQ-028 Verification SHALL cover a nominal single image: N_IMG=1, start, sig_ready 2 cycles after each mac1_last, mac2_done 2 cycles after each mac2_last -> 200 hid_we pulses (waddr 0..199), final w1_addr 156799, 10 out_we pulses (idx 0..9), final w2_addr 1999, one done pulse.
REQ-029 Verification SHALL cover a boundary check: i=1, j=0 -> w1_addr=784, mac1_start=1; i=1, j=783 -> w1_addr=1567, mac1_last=1.
REQ-030 Verification SHALL cover a delayed handshake: sig_ready held 0 for 50 cycles in L1_WAIT -> mac1_en=0 and w1_addr constant throughout; a stray mac2_done during L1_RUN -> no out_we.
REQ-031 Verification SHALL cover abort: abort at i=57 -> busy=0 on the next cycle, no done; a new start then restarts at w1_addr=0 with img_sel=0.
REQ-032 Verification SHALL cover async reset: reset=0 mid-L2_RUN with no clock edge -> all outputs 0 immediately.
REQ-033 Verification SHALL cover multi-image runs: N_IMG=10 -> img_sel steps 0..9, 100 out_we pulses in total, done once; start during busy has no effect.

Source files
------------

// File: rtl/mlp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mlp_seq_ctrl
//   Sequencer for a two-layer MLP inference datapath. For every image it walks
//   the layer-1 weight/input memories neuron by neuron (N_IN MACs per hidden
//   neuron), waits for the sigmoid unit, writes the hidden buffer, then walks
//   the layer-2 weights over the hidden buffer (N_HID MACs per output neuron)
//   and writes each output score. After N_IMG images it pulses done.
//
// Ports
//   clk, reset (async, active-low)
//   start, abort          : run control (start only honoured in IDLE)
//   busy, done            : run in progress / one-cycle completion pulse
//   w1_addr, in_addr      : layer-1 weight and input-pixel addresses
//   img_sel               : input SRAM bank (image) select
//   mac1_en/start/last    : layer-1 MAC enable and first/last-term strobes
//   sig_ready             : sigmoid result available (handshake into L1_WAIT)
//   hid_we, hid_waddr     : hidden-buffer write strobe and address
//   hid_raddr             : hidden-buffer read address for layer 2
//   w2_addr               : layer-2 weight address
//   mac2_en/start/last    : layer-2 MAC enable and first/last-term strobes
//   mac2_done             : layer-2 result available (handshake into L2_WAIT)
//   out_we, out_idx       : output-score write strobe and index
//
// Every output is a flop. Strobes are registered from the next-state decode so
// they line up with the state/counter registers and cannot glitch.
// ---------------------------------------------------------------------------
module mlp_seq_ctrl #(
  parameter int N_IN  = 784,
  parameter int N_HID = 200,
  parameter int N_OUT = 10,
  parameter int N_IMG = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [17:0] w1_addr,
  output logic [9:0]  in_addr,
  output logic [3:0]  img_sel,
  output logic        mac1_en,
  output logic        mac1_start,
  output logic        mac1_last,
  input  logic        sig_ready,
  output logic        hid_we,
  output logic [7:0]  hid_waddr,
  output logic [7:0]  hid_raddr,
  output logic [11:0] w2_addr,
  output logic        mac2_en,
  output logic        mac2_start,
  output logic        mac2_last,
  input  logic        mac2_done,
  output logic        out_we,
  output logic [3:0]  out_idx
);

  typedef enum logic [2:0] {
    IDLE, L1_RUN, L1_WAIT, L2_RUN, L2_WAIT, NEXT_IMG, FIN
  } state_t;

  localparam logic [9:0] J_LAST   = 10'(N_IN - 1);
  localparam logic [7:0] HID_LAST = 8'(N_HID - 1);
  localparam logic [3:0] K_LAST   = 4'(N_OUT - 1);
  localparam logic [3:0] IMG_LAST = 4'(N_IMG - 1);

  state_t      state_q, state_d;
  logic [7:0]  i_q, i_d;          // hidden neuron being computed
  logic [9:0]  j_q, j_d;          // layer-1 input index
  logic [3:0]  k_q, k_d;          // output neuron being computed
  logic [7:0]  h_q, h_d;          // layer-2 hidden index
  logic [3:0]  img_q, img_d;
  logic [17:0] w1_q, w1_d;        // running i*N_IN+j
  logic [11:0] w2_q, w2_d;        // running k*N_HID+h
  logic [7:0]  hid_waddr_q, hid_waddr_d;
  logic [3:0]  out_idx_q, out_idx_d;
  logic        hid_we_q, hid_we_d;
  logic        out_we_q, out_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mac1_en_q, mac1_en_d, mac1_start_q, mac1_start_d, mac1_last_q, mac1_last_d;
  logic        mac2_en_q, mac2_en_d, mac2_start_q, mac2_start_d, mac2_last_q, mac2_last_d;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    h_d         = h_q;
    img_d       = img_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    hid_waddr_d = hid_waddr_q;
    out_idx_d   = out_idx_q;
    hid_we_d    = 1'b0;
    out_we_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = L1_RUN;
          i_d = '0; j_d = '0; k_d = '0; h_d = '0; img_d = '0;
          w1_d = '0; w2_d = '0;
        end
      end
      L1_RUN: begin
        // The address holds on the last term so it is stable through the wait.
        if (j_q == J_LAST) begin
          state_d = L1_WAIT;
        end else begin
          j_d  = j_q + 10'd1;
          w1_d = w1_q + 18'd1;
        end
      end
      L1_WAIT: begin
        if (sig_ready) begin
          hid_we_d    = 1'b1;
          hid_waddr_d = i_q;
          if (i_q != HID_LAST) begin
            state_d = L1_RUN;
            i_d     = i_q + 8'd1;
            j_d     = '0;
            w1_d    = w1_q + 18'd1;   // i*N_IN+N_IN-1 -> (i+1)*N_IN
          end else begin
            state_d = L2_RUN;
            k_d = '0; h_d = '0; w2_d = '0;
          end
        end
      end
      L2_RUN: begin
        if (h_q == HID_LAST) begin
          state_d = L2_WAIT;
        end else begin
          h_d  = h_q + 8'd1;
          w2_d = w2_q + 12'd1;
        end
      end
      L2_WAIT: begin
        if (mac2_done) begin
          out_we_d  = 1'b1;
          out_idx_d = k_q;
          if (k_q != K_LAST) begin
            state_d = L2_RUN;
            k_d     = k_q + 4'd1;
            h_d     = '0;
            w2_d    = w2_q + 12'd1;
          end else begin
            state_d = NEXT_IMG;
          end
        end
      end
      NEXT_IMG: begin
        if (img_q != IMG_LAST) begin
          state_d = L1_RUN;
          img_d   = img_q + 4'd1;
          i_d = '0; j_d = '0; w1_d = '0;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every handshake in the same cycle and drops the run.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      hid_we_d = 1'b0;
      out_we_d = 1'b0;
      i_d = '0; j_d = '0; k_d = '0; h_d = '0; img_d = '0;
      w1_d = '0; w2_d = '0;
    end

    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
    mac1_en_d    = (state_d == L1_RUN);
    mac1_start_d = (state_d == L1_RUN) && (j_d == '0);
    mac1_last_d  = (state_d == L1_RUN) && (j_d == J_LAST);
    mac2_en_d    = (state_d == L2_RUN);
    mac2_start_d = (state_d == L2_RUN) && (h_d == '0);
    mac2_last_d  = (state_d == L2_RUN) && (h_d == HID_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      h_q          <= '0;
      img_q        <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      hid_waddr_q  <= '0;
      out_idx_q    <= '0;
      hid_we_q     <= 1'b0;
      out_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mac1_en_q    <= 1'b0;
      mac1_start_q <= 1'b0;
      mac1_last_q  <= 1'b0;
      mac2_en_q    <= 1'b0;
      mac2_start_q <= 1'b0;
      mac2_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      h_q          <= h_d;
      img_q        <= img_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      hid_waddr_q  <= hid_waddr_d;
      out_idx_q    <= out_idx_d;
      hid_we_q     <= hid_we_d;
      out_we_q     <= out_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mac1_en_q    <= mac1_en_d;
      mac1_start_q <= mac1_start_d;
      mac1_last_q  <= mac1_last_d;
      mac2_en_q    <= mac2_en_d;
      mac2_start_q <= mac2_start_d;
      mac2_last_q  <= mac2_last_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign w1_addr    = w1_q;
  assign in_addr    = j_q;
  assign img_sel    = img_q;
  assign mac1_en    = mac1_en_q;
  assign mac1_start = mac1_start_q;
  assign mac1_last  = mac1_last_q;
  assign hid_we     = hid_we_q;
  assign hid_waddr  = hid_waddr_q;
  assign hid_raddr  = h_q;
  assign w2_addr    = w2_q;
  assign mac2_en    = mac2_en_q;
  assign mac2_start = mac2_start_q;
  assign mac2_last  = mac2_last_q;
  assign out_we     = out_we_q;
  assign out_idx    = out_idx_q;

endmodule
